// File: rtl/bf_wb_pkg.sv
// Shared types and sizing for the writeback scoreboard: register addresses, writeback beats and
// the arbitration source encoding.
package bf_wb_pkg;

  localparam int unsigned NREG         = 16;
  localparam int unsigned AW           = $clog2(NREG);
  localparam int unsigned DW           = 32;
  localparam int unsigned MAX_INFLIGHT = 4;
  localparam int unsigned STARVE_LIM   = 3;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] wb_data_t;

  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_FPU} wb_src_e;

  typedef struct packed {
    reg_addr_t wa;
    wb_data_t  wd;
    logic      we;
  } wb_beat_t;

  function automatic logic [NREG-1:0] reg_onehot(input reg_addr_t addr, input logic en);
    reg_onehot = en ? (NREG'(1) << addr) : '0;
  endfunction

endpackage

// File: rtl/wb_arbiter.sv
// Fixed-priority ALU/FPU writeback mux; counts cycles an offered FPU result loses to the ALU and
// flags saturation so issue can be throttled until the FPU wins.
module wb_arbiter
  import bf_wb_pkg::*;
#(
  parameter int unsigned StarveLim = STARVE_LIM
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_wa,
  input  logic [DW-1:0]   alu_wd,
  input  logic            fpu_valid,
  input  logic [AW-1:0]   fpu_wa,
  input  logic [DW-1:0]   fpu_wd,
  output logic            fpu_ready,
  output wb_beat_t        beat,
  output logic            starve_sat
);

  localparam int unsigned SW = $clog2(StarveLim + 1);

  wb_src_e       src;
  logic [SW-1:0] starve_q, starve_d;

  always_comb begin
    src = WB_NONE;
    if (alu_valid) begin
      src = WB_ALU;
    end else if (fpu_valid) begin
      src = WB_FPU;
    end
  end

  always_comb begin
    beat = '0;
    case (src)
      WB_ALU:  beat = '{wa: alu_wa, wd: alu_wd, we: 1'b1};
      WB_FPU:  beat = '{wa: fpu_wa, wd: fpu_wd, we: 1'b1};
      default: beat = '0;
    endcase
  end

  assign fpu_ready  = (src == WB_FPU);
  assign starve_sat = (starve_q == SW'(StarveLim));

  // Any cycle the FPU is not blocked (accepted or not offering) ends the starvation run.
  always_comb begin
    starve_d = '0;
    if (fpu_valid && alu_valid) begin
      starve_d = starve_sat ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/writeback_scoreboard.sv
// Owns the RF write port, tracks destinations of in-flight FPU ops and stalls decode on hazards.
// Define SB_PERF_EN to add the stall_cnt / fpu_defer_cnt performance counters.
module writeback_scoreboard
  import bf_wb_pkg::*;
#(
  parameter int unsigned MaxInflight = MAX_INFLIGHT,
  parameter int unsigned StarveLim   = STARVE_LIM
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  logic          issue_fpu,
  input  logic          issue_we,
  input  logic [AW-1:0] issue_rd,
  input  logic [AW-1:0] issue_rs1,
  input  logic [AW-1:0] issue_rs2,
  output logic          issue_stall,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_wa,
  input  logic [DW-1:0] alu_wd,
  input  logic          fpu_valid,
  input  logic [AW-1:0] fpu_wa,
  input  logic [DW-1:0] fpu_wd,
  output logic          fpu_ready,
  output logic [AW-1:0] WA3W,
  output logic [DW-1:0] WD3W,
  output logic          RegWriteW
`ifdef SB_PERF_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   fpu_defer_cnt
`endif
);

  localparam int unsigned IW = $clog2(MaxInflight + 1);

  logic [NREG-1:0] pending_q, pending_d, pending_vis, fpu_clr, issue_set;
  logic [IW-1:0]   inflight_q, inflight_d, inflight_vis;
  wb_beat_t        beat;
  logic            starve_sat, fpu_dec, hazard, issue_acc;

  wb_arbiter #(
    .StarveLim (StarveLim)
  ) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_wa     (alu_wa),
    .alu_wd     (alu_wd),
    .fpu_valid  (fpu_valid),
    .fpu_wa     (fpu_wa),
    .fpu_wd     (fpu_wd),
    .fpu_ready  (fpu_ready),
    .beat       (beat),
    .starve_sat (starve_sat)
  );

  assign WA3W      = beat.wa;
  assign WD3W      = beat.wd;
  assign RegWriteW = beat.we;

  // The completing FPU beat is forwarded this cycle, so its register and slot count as free now.
  // A completion with nothing in flight must not underflow the counter.
  assign fpu_dec      = fpu_ready && (inflight_q != '0);
  assign fpu_clr      = reg_onehot(fpu_wa, fpu_ready);
  assign pending_vis  = pending_q & ~fpu_clr;
  assign inflight_vis = inflight_q - IW'(fpu_dec);

  assign hazard = pending_vis[issue_rs1] | pending_vis[issue_rs2] |
                  (issue_we & pending_vis[issue_rd]);

  assign issue_stall = issue_valid &
                       (hazard | (issue_fpu & (inflight_vis == IW'(MaxInflight))) | starve_sat);
  assign issue_acc   = issue_valid & ~issue_stall;

  // Set is OR-ed after the clear so a new op to the completing register keeps the bit.
  assign issue_set  = reg_onehot(issue_rd, issue_acc & issue_fpu & issue_we);
  assign pending_d  = pending_vis | issue_set;
  assign inflight_d = inflight_vis + IW'(|issue_set);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      inflight_q <= '0;
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef SB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt     <= '0;
      fpu_defer_cnt <= '0;
    end else begin
      stall_cnt     <= stall_cnt + 32'(issue_stall);
      fpu_defer_cnt <= fpu_defer_cnt + 32'(fpu_valid & ~fpu_ready);
    end
  end
`endif

endmodule
